// File: rtl/aixh_mxc_inner_seq_pkg.sv
// Shared MxConv types: forward command encoding, job descriptor,
// inner-sequencer FSM states and widths.
package AIXH_MXC_pkg;

  localparam int CMD_W = 3;
  localparam int LEN_W = 12;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 3'd0,
    CMD_CLR   = 3'd1,
    CMD_WLOAD = 3'd2,
    CMD_MAC   = 3'd3,
    CMD_FLUSH = 3'd4
  } aixh_mxc_fwd_cmd_e;

  typedef struct packed {
    logic             clr;
    logic [LEN_W-1:0] wlen;
    logic [LEN_W-1:0] alen;
  } aixh_mxc_job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_WLOAD,
    ST_MAC,
    ST_FLUSH,
    ST_DRAIN
  } aixh_mxc_seq_st_e;

  // First phase still owed by a job; empty phases are skipped.
  function automatic aixh_mxc_seq_st_e first_st(
    input logic             clr,
    input logic [LEN_W-1:0] wlen,
    input logic [LEN_W-1:0] alen
  );
    if (clr)             return ST_CLR;
    else if (wlen != '0) return ST_WLOAD;
    else if (alen != '0) return ST_MAC;
    else                 return ST_FLUSH;
  endfunction

endpackage

// File: rtl/aixh_mxc_inner_seq_if.sv
// Scheduler-side job handshake plus array horizontal command/result bus.
// Perf counter outputs exist only with AIXH_MXC_SEQ_PERF_EN defined.
interface aixh_mxc_inner_seq_if
  import AIXH_MXC_pkg::*;
#(
  parameter int YCOUNT = 4
) ();

  logic                    i_job_vld;
  logic                    o_job_rdy;
  logic                    i_job_clr;
  logic [LEN_W-1:0]        i_job_wlen;
  logic [LEN_W-1:0]        i_job_alen;
  logic                    i_fwd_stall;
  logic [YCOUNT*CMD_W-1:0] o_fwd_cmd;
  logic [YCOUNT-1:0]       i_bwd_vld;
  logic                    o_busy;
  logic                    o_done;

`ifdef AIXH_MXC_SEQ_PERF_EN
  logic [31:0] o_perf_busy_cyc;
  logic [31:0] o_perf_stall_cyc;

  modport master (
    output i_job_vld, i_job_clr, i_job_wlen, i_job_alen,
    output i_fwd_stall, i_bwd_vld,
    input  o_job_rdy, o_fwd_cmd, o_busy, o_done,
    input  o_perf_busy_cyc, o_perf_stall_cyc
  );

  modport slave (
    input  i_job_vld, i_job_clr, i_job_wlen, i_job_alen,
    input  i_fwd_stall, i_bwd_vld,
    output o_job_rdy, o_fwd_cmd, o_busy, o_done,
    output o_perf_busy_cyc, o_perf_stall_cyc
  );
`else
  modport master (
    output i_job_vld, i_job_clr, i_job_wlen, i_job_alen,
    output i_fwd_stall, i_bwd_vld,
    input  o_job_rdy, o_fwd_cmd, o_busy, o_done
  );

  modport slave (
    input  i_job_vld, i_job_clr, i_job_wlen, i_job_alen,
    input  i_fwd_stall, i_bwd_vld,
    output o_job_rdy, o_fwd_cmd, o_busy, o_done
  );
`endif

endinterface

// File: rtl/aixh_mxc_inner_seq_skew.sv
// Row skew line: row y is row 0 delayed by y*SKEW flops.
module aixh_mxc_inner_seq_skew #(
  parameter int YCOUNT = 4,
  parameter int SKEW   = 1,
  parameter int CMD_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CMD_W-1:0]        row0_i,
  output logic [YCOUNT*CMD_W-1:0] rows_o,
  output logic                    empty_o
);

  localparam int D = (YCOUNT - 1) * SKEW;

  logic [CMD_W-1:0] line_q [1:D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= D; k++) line_q[k] <= '0;
    end else begin
      line_q[1] <= row0_i;
      for (int k = 2; k <= D; k++) line_q[k] <= line_q[k-1];
    end
  end

  always_comb begin
    rows_o = '0;
    rows_o[0 +: CMD_W] = row0_i;
    for (int y = 1; y < YCOUNT; y++)
      rows_o[CMD_W*y +: CMD_W] = line_q[y*SKEW];
  end

  // Empty covers every stage, not just the visible lanes.
  always_comb begin
    empty_o = (row0_i == '0);
    for (int k = 1; k <= D; k++)
      if (line_q[k] != '0) empty_o = 1'b0;
  end

endmodule

// File: rtl/aixh_mxc_inner_seq.sv
// MxConv inner-tile job sequencer: CLR/WLOAD/MAC/FLUSH issue, result count.
// Optional perf counters: define AIXH_MXC_SEQ_PERF_EN.
module aixh_mxc_inner_seq
  import AIXH_MXC_pkg::*;
#(
  parameter int YCOUNT  = 4,
  parameter int SKEW    = 1,
  parameter int FLUSH_N = 2
) (
  input logic aixh_core_clk2x,
  input logic aixh_core_rstn2x,
  aixh_mxc_inner_seq_if.slave bus
);

  aixh_mxc_seq_st_e  state_q, state_d;
  aixh_mxc_job_t     job_q, job_d;
  aixh_mxc_fwd_cmd_e cmd0_q, cmd0_d;
  logic [LEN_W-1:0]  wcnt_q, wcnt_d;
  logic [LEN_W-1:0]  acnt_q, acnt_d;
  logic [LEN_W-1:0]  rcnt_q, rcnt_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              done;
  logic              issue;
  logic              skew_empty;
  logic              unused_bwd;

  assign issue      = !bus.i_fwd_stall;
  assign unused_bwd = ^bus.i_bwd_vld;

  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
    if (!aixh_core_rstn2x) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
      cmd0_q  <= CMD_NOP;
      wcnt_q  <= '0;
      acnt_q  <= '0;
      rcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      cmd0_q  <= cmd0_d;
      wcnt_q  <= wcnt_d;
      acnt_q  <= acnt_d;
      rcnt_q  <= rcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    cmd0_d  = CMD_NOP;
    wcnt_d  = wcnt_q;
    acnt_d  = acnt_q;
    rcnt_d  = rcnt_q;
    fcnt_d  = fcnt_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.i_job_vld) begin
        job_d = '{clr:  bus.i_job_clr,
                  wlen: bus.i_job_wlen,
                  alen: bus.i_job_alen};
        state_d = first_st(bus.i_job_clr,
                           bus.i_job_wlen,
                           bus.i_job_alen);
        wcnt_d = '0;
        acnt_d = '0;
        rcnt_d = '0;
        fcnt_d = '0;
      end
      ST_CLR: if (issue) begin
        cmd0_d  = CMD_CLR;
        state_d = first_st(1'b0, job_q.wlen, job_q.alen);
      end
      ST_WLOAD: if (issue) begin
        cmd0_d = CMD_WLOAD;
        // Compare before increment so wlen = all-ones never wraps.
        if (wcnt_q == job_q.wlen - LEN_W'(1)) begin
          wcnt_d  = '0;
          state_d = (job_q.alen != '0) ? ST_MAC : ST_FLUSH;
        end else begin
          wcnt_d = wcnt_q + LEN_W'(1);
        end
      end
      ST_MAC: if (issue) begin
        cmd0_d = CMD_MAC;
        if (acnt_q == job_q.alen - LEN_W'(1)) begin
          acnt_d  = '0;
          state_d = ST_FLUSH;
        end else begin
          acnt_d = acnt_q + LEN_W'(1);
        end
      end
      ST_FLUSH: if (issue) begin
        cmd0_d = CMD_FLUSH;
        if (fcnt_q == 8'(FLUSH_N - 1)) begin
          fcnt_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
      ST_DRAIN: if (rcnt_q == job_q.alen && skew_empty) begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Results saturate at alen; idle pulses are dropped.
    if (state_q != ST_IDLE && bus.i_bwd_vld[YCOUNT-1] &&
        rcnt_q != job_q.alen)
      rcnt_d = rcnt_q + LEN_W'(1);
  end

  aixh_mxc_inner_seq_skew #(
    .YCOUNT (YCOUNT),
    .SKEW   (SKEW),
    .CMD_W  (CMD_W)
  ) u_skew (
    .clk     (aixh_core_clk2x),
    .rst_n   (aixh_core_rstn2x),
    .row0_i  (cmd0_q),
    .rows_o  (bus.o_fwd_cmd),
    .empty_o (skew_empty)
  );

  assign bus.o_job_rdy = (state_q == ST_IDLE);
  assign bus.o_busy    = (state_q != ST_IDLE);
  assign bus.o_done    = done;

`ifdef AIXH_MXC_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;
  logic        accept;
  logic        stall_gate;

  assign accept     = (state_q == ST_IDLE) && bus.i_job_vld;
  assign stall_gate = bus.i_fwd_stall &&
                      (state_q inside {ST_CLR, ST_WLOAD,
                                       ST_MAC, ST_FLUSH});

  always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
    if (!aixh_core_rstn2x) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if (accept) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (bus.o_busy && !(&perf_busy_q))
        perf_busy_q <= perf_busy_q + 32'd1;
      if (stall_gate && !(&perf_stall_q))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.o_perf_busy_cyc  = perf_busy_q;
  assign bus.o_perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_aixh_mxc_inner_seq.sv
// Bench for aixh_mxc_inner_seq: job table, directed corners, random vs model.
module tb_aixh_mxc_inner_seq;
  import AIXH_MXC_pkg::*;

  localparam int Y = 4;
  localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, WLD = 3'd2;
  localparam logic [2:0] MAC = 3'd3, FLS = 3'd4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  aixh_mxc_inner_seq_if #(.YCOUNT(Y)) bus ();

  aixh_mxc_inner_seq #(
    .YCOUNT(Y), .SKEW(1), .FLUSH_N(2)
  ) dut (
    .aixh_core_clk2x  (clk),
    .aixh_core_rstn2x (rstn),
    .bus              (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] row(input int y);
    return bus.o_fwd_cmd[3*y +: 3];
  endfunction

  task automatic idle_in();
    bus.i_job_vld   = 1'b0;
    bus.i_job_clr   = 1'b0;
    bus.i_job_wlen  = '0;
    bus.i_job_alen  = '0;
    bus.i_fwd_stall = 1'b0;
    bus.i_bwd_vld   = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input bit c, input int w, input int a);
    bus.i_job_vld  = 1'b1;
    bus.i_job_clr  = c;
    bus.i_job_wlen = LEN_W'(w);
    bus.i_job_alen = LEN_W'(a);
  endtask

  // Command order owed by a job, straight from the descriptor.
  logic [2:0] exp_q[$];
  task automatic build_q(input bit c, input int w, input int a);
    exp_q.delete();
    if (c) exp_q.push_back(CLR);
    repeat (w) exp_q.push_back(WLD);
    repeat (a) exp_q.push_back(MAC);
    repeat (2) exp_q.push_back(FLS);
  endtask

  // Unstalled job, alen early result pulses; lat = accept->done.
  task automatic run_job(input bit c, input int w, input int a,
                         input int lat);
    int n, bad0, bad3, nd, dt;
    logic [2:0] e0, e3;
    build_q(c, w, a);
    n = exp_q.size();
    bad0 = 0; bad3 = 0; nd = 0; dt = -1;
    set_job(c, w, a);
    @(negedge clk);
    chk("job_rdy", bus.o_job_rdy, 1);
    cyc();
    bus.i_job_vld = 1'b0;
    for (int t = 1; t <= lat + 2; t++) begin
      bus.i_bwd_vld = (t <= a) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      e0 = (t >= 2 && t - 2 < n) ? exp_q[t-2] : NOP;
      e3 = (t >= 5 && t - 5 < n) ? exp_q[t-5] : NOP;
      if (row(0) !== e0) bad0++;
      if (row(3) !== e3) bad3++;
      if (bus.o_done) begin
        nd++;
        if (dt < 0) dt = t;
      end
      cyc();
    end
    bus.i_bwd_vld = '0;
    chk("seq_row0", bad0, 0);
    chk("seq_row3", bad3, 0);
    chk("done_lat", dt, lat);
    chk("done_cnt", nd, 1);
  endtask

  typedef struct {
    bit c;
    int w;
    int a;
    int lat;
  } vec_t;

  // Behavioural model: pending-command queue plus row history.
  bit         m_busy;
  int         m_alen, m_rcnt;
  logic [2:0] m_q[$];
  logic [2:0] m_h[4];

  function automatic bit m_done();
    return m_busy && m_q.size() == 0 && m_rcnt == m_alen &&
           m_h[0] == NOP && m_h[1] == NOP &&
           m_h[2] == NOP && m_h[3] == NOP;
  endfunction

  task automatic m_step();
    bit d;
    logic [2:0] nr;
    d = m_done();
    nr = NOP;
    if (m_busy && m_q.size() > 0 && !bus.i_fwd_stall)
      nr = m_q.pop_front();
    for (int k = 3; k > 0; k--) m_h[k] = m_h[k-1];
    m_h[0] = nr;
    if (m_busy && bus.i_bwd_vld[3] && m_rcnt < m_alen) m_rcnt++;
    if (d) m_busy = 0;
    else if (!m_busy && bus.i_job_vld) begin
      build_q(bus.i_job_clr, int'(bus.i_job_wlen),
              int'(bus.i_job_alen));
      m_q = exp_q;
      m_alen = int'(bus.i_job_alen);
      m_rcnt = 0;
      m_busy = 1;
    end
  endtask

  initial begin
    vec_t vt[7];
    logic [2:0] st_exp[7];
    logic [2:0] e;
    int bad, nm, nd, dt;
    logic [14:0] act, expv;

    vt[0] = '{1, 3, 5, 16};
    vt[1] = '{0, 0, 0, 7};
    vt[2] = '{0, 1, 0, 8};
    vt[3] = '{1, 0, 2, 10};
    vt[4] = '{0, 4, 1, 12};
    vt[5] = '{0, 4095, 0, 4102};
    vt[6] = '{0, 0, 4095, 4102};
    st_exp = '{MAC, NOP, NOP, MAC, MAC, MAC, FLS};

    idle_in();
    #12;
    chk("rst_lanes", bus.o_fwd_cmd, 0);
    chk("rst_ctl", {bus.o_job_rdy, bus.o_busy, bus.o_done}, 3'b100);
    @(negedge clk);
    rstn = 1'b1;
    cyc();

    foreach (vt[i]) run_job(vt[i].c, vt[i].w, vt[i].a, vt[i].lat);

    // Last result arrives well after the skew line drained.
    set_job(1, 3, 5);
    cyc();
    bus.i_job_vld = 1'b0;
    nd = 0; dt = -1;
    for (int t = 1; t <= 27; t++) begin
      bus.i_bwd_vld = (t <= 4 || t == 25) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (t == 20) chk("late_busy", bus.o_busy, 1);
      if (bus.o_done) begin
        nd++;
        if (dt < 0) dt = t;
      end
      cyc();
    end
    chk("late_done_t", dt, 26);
    chk("late_done_n", nd, 1);

    // Stall on MAC cycles 2-3.
    set_job(0, 0, 4);
    cyc();
    bus.i_job_vld = 1'b0;
    bad = 0; nm = 0; nd = 0; dt = -1;
    for (int t = 1; t <= 30; t++) begin
      bus.i_fwd_stall = (t == 2 || t == 3);
      bus.i_bwd_vld = (t >= 3 && t <= 6) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (t >= 2 && t <= 8) begin
        e = st_exp[t-2];
        if (row(0) !== e) bad++;
      end
      if (row(0) === MAC) nm++;
      if (bus.o_done) begin
        nd++;
        if (dt < 0) dt = t;
      end
      cyc();
    end
    bus.i_fwd_stall = 1'b0;
    bus.i_bwd_vld = '0;
    chk("stall_seq", bad, 0);
    chk("stall_macs", nm, 4);
    chk("stall_done_t", dt, 13);
    chk("stall_done_n", nd, 1);

    // Excess results saturate; idle results are ignored.
    set_job(0, 0, 2);
    cyc();
    bus.i_job_vld = 1'b0;
    nd = 0; dt = -1;
    for (int t = 1; t <= 14; t++) begin
      bus.i_bwd_vld = (t <= 4) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (bus.o_done) begin
        nd++;
        if (dt < 0) dt = t;
      end
      cyc();
    end
    chk("xs_done_t", dt, 9);
    chk("xs_done_n", nd, 1);
    bus.i_bwd_vld = 4'b1111;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("idle_bwd", {bus.o_job_rdy, bus.o_busy, bus.o_done,
                       bus.o_fwd_cmd}, {3'b100, 12'h000});
      cyc();
    end
    bus.i_bwd_vld = '0;

    // Asynchronous reset in the middle of MAC.
    set_job(0, 0, 8);
    cyc();
    bus.i_job_vld = 1'b0;
    cyc();
    cyc();
    #2;
    chk("pre_rst_row0", row(0), MAC);
    rstn = 1'b0;
    #1;
    chk("arst_lanes", bus.o_fwd_cmd, 0);
    chk("arst_ctl", {bus.o_job_rdy, bus.o_busy, bus.o_done}, 3'b100);
    @(negedge clk);
    rstn = 1'b1;
    nd = 0;
    for (int t = 0; t < 10; t++) begin
      bus.i_bwd_vld = 4'b1000;
      @(negedge clk);
      if (bus.o_done) nd++;
      cyc();
    end
    bus.i_bwd_vld = '0;
    chk("arst_no_done", nd, 0);
    run_job(1, 2, 3, 13);

    // Back-to-back: second descriptor waits on valid.
    set_job(0, 1, 0);
    cyc();
    set_job(1, 0, 0);
    nd = 0; dt = -1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 9) chk("b2b_rdy", bus.o_job_rdy, 1);
      if (t == 10) chk("b2b_busy", {bus.o_job_rdy, bus.o_busy}, 2'b01);
      if (t == 11) chk("b2b_clr", row(0), CLR);
      if (bus.o_done) begin
        nd++;
        if (dt < 0) dt = t;
        else chk("b2b_done2_t", t, 17);
      end
      cyc();
      if (t == 9) bus.i_job_vld = 1'b0;
    end
    chk("b2b_done1_t", dt, 8);
    chk("b2b_done_n", nd, 2);

    // Randomized traffic against the model, from a clean reset.
    idle_in();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m_busy = 0; m_alen = 0; m_rcnt = 0;
    m_q.delete();
    foreach (m_h[k]) m_h[k] = NOP;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      m_step();
      #1;
      bus.i_job_vld   = ($urandom_range(0, 1) == 0);
      bus.i_job_clr   = $urandom_range(0, 1) == 1;
      bus.i_job_wlen  = LEN_W'($urandom_range(0, 4));
      bus.i_job_alen  = LEN_W'($urandom_range(0, 6));
      bus.i_fwd_stall = ($urandom_range(0, 3) == 0);
      bus.i_bwd_vld   = {($urandom_range(0, 2) == 0),
                         3'($urandom_range(0, 7))};
      @(negedge clk);
      act  = {bus.o_job_rdy, bus.o_busy, bus.o_done, bus.o_fwd_cmd};
      expv = {!m_busy, m_busy, m_done(),
              m_h[3], m_h[2], m_h[1], m_h[0]};
      chk("rand", act, expv);
    end
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
